// File: rtl/uart_cmd_decoder.sv
// ASCII command-line decoder: letter + optional hex operand + CR/LF, presented on valid/ready.
// Malformed lines raise a one-cycle error strobe and are dropped up to the next terminator.
module uart_cmd_decoder #(
  parameter  int ARG_W      = 24,
  localparam int MAX_DIGITS = ARG_W / 4
) (
  input  logic             clk,
  input  logic             anrst,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  input  logic             rx_err,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       cmd_op,
  output logic [ARG_W-1:0] cmd_arg,
  output logic             cmd_has_arg,
  output logic             err_strobe,
  output logic [1:0]       err_code
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] E_BADCHAR  = 2'd0;
  localparam logic [1:0] E_OVERFLOW = 2'd1;
  localparam logic [1:0] E_FRAMING  = 2'd2;
  localparam logic [1:0] E_OVERRUN  = 2'd3;

  typedef enum logic [1:0] {IDLE, ARG, HOLD, DISCARD} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             overrun;

  function automatic logic is_term(input logic [7:0] c);
    return (c == 8'h0D) || (c == 8'h0A);
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Letters 'A'-'F' and 'a'-'f' share the low nibble 1..6, offset by 9 to reach 10..15.
  function automatic logic [3:0] hex_nib(input logic [7:0] c);
    if (c <= 8'h39) return c[3:0];
    return c[3:0] + 4'd9;
  endfunction

  logic byte_ok;
  logic hold_event;

  assign byte_ok    = rx_done & ~rx_err;
  assign hold_event = rx_done | rx_err;

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state       <= IDLE;
      count       <= '0;
      overrun     <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_op      <= '0;
      cmd_arg     <= '0;
      cmd_has_arg <= 1'b0;
      err_strobe  <= 1'b0;
      err_code    <= '0;
    end else begin
      err_strobe <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_err) begin
            err_strobe <= 1'b1;
            err_code   <= E_FRAMING;
            state      <= DISCARD;
          end else if (rx_done) begin
            if (is_letter(rx_data)) begin
              cmd_op  <= {rx_data[7:6], 1'b0, rx_data[4:0]};
              cmd_arg <= '0;
              count   <= '0;
              state   <= ARG;
            end else if (!is_term(rx_data) && (rx_data != 8'h20)) begin
              err_strobe <= 1'b1;
              err_code   <= E_BADCHAR;
              state      <= DISCARD;
            end
          end
        end

        ARG: begin
          if (rx_err) begin
            err_strobe <= 1'b1;
            err_code   <= E_FRAMING;
            state      <= DISCARD;
          end else if (rx_done) begin
            if (is_term(rx_data)) begin
              cmd_has_arg <= (count != '0);
              cmd_valid   <= 1'b1;
              state       <= HOLD;
            end else if (is_hex(rx_data)) begin
              if (count == CNT_W'(MAX_DIGITS)) begin
                err_strobe <= 1'b1;
                err_code   <= E_OVERFLOW;
                state      <= DISCARD;
              end else begin
                cmd_arg <= (cmd_arg << 4) | ARG_W'(hex_nib(rx_data));
                count   <= count + 1'b1;
              end
            end else begin
              err_strobe <= 1'b1;
              err_code   <= E_BADCHAR;
              state      <= DISCARD;
            end
          end
        end

        // Any byte arriving while a command waits is lost; the rest of its line must be skipped.
        HOLD: begin
          if (hold_event) begin
            err_strobe <= 1'b1;
            err_code   <= rx_err ? E_FRAMING : E_OVERRUN;
          end
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            overrun   <= 1'b0;
            state     <= (overrun || hold_event) ? DISCARD : IDLE;
          end else if (hold_event) begin
            overrun <= 1'b1;
          end
        end

        DISCARD: begin
          if (byte_ok && is_term(rx_data)) state <= IDLE;
        end
      endcase
    end
  end

endmodule
